// File: rtl/down_timer.sv
// Loadable down-counter with one-shot / periodic auto-reload and a
// registered one-cycle terminal-count pulse.
module down_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             periodic,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;

      if (load) begin
         // A zero load parks the timer without ever signalling expiry.
         reload_d = load_val;
         count_d  = load_val;
         state_d  = (load_val != '0) ? RUN : IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            RUN: begin
               if (en) begin
                  if (count_q > WIDTH'(1)) begin
                     count_d = count_q - WIDTH'(1);
                  end else if (count_q == WIDTH'(1)) begin
                     count_d = '0;
                     tc_d    = 1'b1;
                     state_d = periodic ? RUN : IDLE;
                  end else if (periodic) begin
                     // The extra cycle spent at zero gives a period of reload+1.
                     count_d = reload_q;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign count = count_q;
   assign busy  = (state_q == RUN);
   assign tc    = tc_q;

endmodule
